// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard/control unit that sits beside the four pipeline registers. It
//   produces their stall/squash/write-enable controls and the EX-stage
//   forwarding selects from the stage outputs it observes.
//   Handles load-use hazards, taken branches/jumps, data-memory wait states
//   and the halt drain. Also keeps saturating stall/squash event counters.
// Ports
//   CLK, RST              clock, asynchronous active-high reset
//   *_id                  ID-stage valid, sources, source-use flags, halt
//   *_ex                  EX-stage valid, sources, rd, write enable (active-low),
//                         writeback select, branch-taken
//   *_mem / *_wb          MEM/WB valid, rd, write enable (active-low);
//                         halt_wb marks the halt reaching WB
//   mem_busy              data memory not ready this cycle
//   pc_hold, stall_*,
//   squash_*, WEN_back    pipeline register controls (WEN_back 1 = freeze)
//   FwdA_ex/FwdB_ex       00 register file, 01 MEM, 10 WB
//   halt_out              processor halted (registered)
//   stall_cnt/squash_cnt  saturating event counters
module pipe_hazard_ctrl #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             valid_id,
    input  logic [4:0]       Rsrc1_id,
    input  logic [4:0]       Rsrc2_id,
    input  logic             Uses_rs1_id,
    input  logic             Uses_rs2_id,
    input  logic             halt_id,
    input  logic             valid_ex,
    input  logic [4:0]       Rsrc1_ex,
    input  logic [4:0]       Rsrc2_ex,
    input  logic [4:0]       RegDst_ex,
    input  logic             RWrEn_ex,
    input  logic [1:0]       WBSel_ex,
    input  logic             BrTaken_ex,
    input  logic             valid_mem,
    input  logic [4:0]       Rdst_mem,
    input  logic             RWrEn_mem,
    input  logic             mem_busy,
    input  logic             valid_wb,
    input  logic [4:0]       Rdst_wb,
    input  logic             RWrEn_wb,
    input  logic             halt_wb,
    output logic             pc_hold,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             squash_if_id,
    output logic             squash_id_ex,
    output logic             WEN_back,
    output logic [1:0]       FwdA_ex,
    output logic [1:0]       FwdB_ex,
    output logic             halt_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    typedef enum logic [1:0] {RUN, LU_STALL, DRAIN, HALTED} state_t;

    // Bubbles remaining after the first one, loaded when a load-use is seen.
    localparam logic [1:0] BUB_INIT = 2'(LOAD_USE_BUBBLES - 1);

    state_t     state, nxt_state;
    logic [1:0] bub_cnt, nxt_bub;
    logic       stall_evt, squash_evt;

    // Forwarding: MEM wins over WB; x0 is never forwarded.
    logic mem_wr, wb_wr;
    assign mem_wr = valid_mem && !RWrEn_mem && (Rdst_mem != 5'd0);
    assign wb_wr  = valid_wb  && !RWrEn_wb  && (Rdst_wb  != 5'd0);

    always_comb begin
        FwdA_ex = 2'b00;
        if (mem_wr && Rdst_mem == Rsrc1_ex)     FwdA_ex = 2'b01;
        else if (wb_wr && Rdst_wb == Rsrc1_ex)  FwdA_ex = 2'b10;
        FwdB_ex = 2'b00;
        if (mem_wr && Rdst_mem == Rsrc2_ex)     FwdB_ex = 2'b01;
        else if (wb_wr && Rdst_wb == Rsrc2_ex)  FwdB_ex = 2'b10;
    end

    // Load in EX whose destination is read by the instruction in ID.
    logic lu;
    assign lu = valid_ex && (WBSel_ex == 2'b10) && !RWrEn_ex && (RegDst_ex != 5'd0) && valid_id
             && ((Uses_rs1_id && Rsrc1_id == RegDst_ex) || (Uses_rs2_id && Rsrc2_id == RegDst_ex));

    always_comb begin
        pc_hold      = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        squash_if_id = 1'b0;
        squash_id_ex = 1'b0;
        WEN_back     = 1'b0;
        nxt_state    = state;
        nxt_bub      = bub_cnt;
        stall_evt    = 1'b0;
        squash_evt   = 1'b0;
        if (state == HALTED) begin
            pc_hold     = 1'b1;
            stall_if_id = 1'b1;
            stall_id_ex = 1'b1;
            WEN_back    = 1'b1;
        end else if (mem_busy) begin
            // Whole pipe freezes; FSM state and bubble count are held.
            pc_hold     = 1'b1;
            stall_if_id = 1'b1;
            stall_id_ex = 1'b1;
            WEN_back    = 1'b1;
            stall_evt   = 1'b1;
        end else if (BrTaken_ex) begin
            // Wrong-path IF and ID are flushed, which also cancels any
            // pending load-use stall or halt drain.
            squash_if_id = 1'b1;
            squash_id_ex = 1'b1;
            squash_evt   = 1'b1;
            nxt_state    = RUN;
            nxt_bub      = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (lu) begin
                        pc_hold      = 1'b1;
                        stall_if_id  = 1'b1;
                        squash_id_ex = 1'b1;
                        stall_evt    = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            nxt_state = LU_STALL;
                            nxt_bub   = BUB_INIT;
                        end
                    end else if (halt_id && valid_id) begin
                        nxt_state = DRAIN;
                    end
                end
                LU_STALL: begin
                    pc_hold      = 1'b1;
                    stall_if_id  = 1'b1;
                    squash_id_ex = 1'b1;
                    stall_evt    = 1'b1;
                    nxt_bub      = bub_cnt - 2'd1;
                    if (bub_cnt == 2'd1) nxt_state = RUN;
                end
                DRAIN: begin
                    // Stop fetching; instructions already past ID keep moving.
                    pc_hold      = 1'b1;
                    squash_if_id = 1'b1;
                    if (halt_wb) nxt_state = HALTED;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= RUN;
            bub_cnt    <= 2'd0;
            halt_out   <= 1'b0;
            stall_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            state    <= nxt_state;
            bub_cnt  <= nxt_bub;
            halt_out <= (nxt_state == HALTED);
            if (stall_evt && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (squash_evt && squash_cnt != '1)
                squash_cnt <= squash_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       valid_id;
        logic [4:0] rs1_id, rs2_id;
        logic       u1, u2, halt_id;
        logic       valid_ex;
        logic [4:0] rs1_ex, rs2_ex, rd_ex;
        logic       rwen_ex;
        logic [1:0] wbsel_ex;
        logic       br;
        logic       valid_mem;
        logic [4:0] rd_mem;
        logic       rwen_mem, busy;
        logic       valid_wb;
        logic [4:0] rd_wb;
        logic       rwen_wb, halt_wb;
    } in_t;

    typedef struct packed {
        logic        ph, sif, sid, qif, qid, wen;
        logic [1:0]  fa, fb;
        logic        ho;
        logic [31:0] sc, qc;
    } exp_t;

    // Abstract model state: mode flags plus number of stall cycles still owed.
    typedef struct {
        bit     halted;
        bit     draining;
        int     lu_left;
        longint scnt;
        longint qcnt;
    } mst_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    in_t  v   = '0;

    always #5 CLK = ~CLK;

    // DUT A: 1 bubble, 4-bit counters (saturation reachable). DUT B: 3 bubbles.
    logic       a_ph, a_sif, a_sid, a_qif, a_qid, a_wen, a_ho;
    logic [1:0] a_fa, a_fb;
    logic [3:0] a_sc, a_qc;
    logic       b_ph, b_sif, b_sid, b_qif, b_qid, b_wen, b_ho;
    logic [1:0] b_fa, b_fb;
    logic [31:0] b_sc, b_qc;

    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(1), .CNT_W(4)) dut_a (
        .CLK(CLK), .RST(RST),
        .valid_id(v.valid_id), .Rsrc1_id(v.rs1_id), .Rsrc2_id(v.rs2_id),
        .Uses_rs1_id(v.u1), .Uses_rs2_id(v.u2), .halt_id(v.halt_id),
        .valid_ex(v.valid_ex), .Rsrc1_ex(v.rs1_ex), .Rsrc2_ex(v.rs2_ex),
        .RegDst_ex(v.rd_ex), .RWrEn_ex(v.rwen_ex), .WBSel_ex(v.wbsel_ex),
        .BrTaken_ex(v.br), .valid_mem(v.valid_mem), .Rdst_mem(v.rd_mem),
        .RWrEn_mem(v.rwen_mem), .mem_busy(v.busy), .valid_wb(v.valid_wb),
        .Rdst_wb(v.rd_wb), .RWrEn_wb(v.rwen_wb), .halt_wb(v.halt_wb),
        .pc_hold(a_ph), .stall_if_id(a_sif), .stall_id_ex(a_sid),
        .squash_if_id(a_qif), .squash_id_ex(a_qid), .WEN_back(a_wen),
        .FwdA_ex(a_fa), .FwdB_ex(a_fb), .halt_out(a_ho),
        .stall_cnt(a_sc), .squash_cnt(a_qc)
    );

    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(3), .CNT_W(32)) dut_b (
        .CLK(CLK), .RST(RST),
        .valid_id(v.valid_id), .Rsrc1_id(v.rs1_id), .Rsrc2_id(v.rs2_id),
        .Uses_rs1_id(v.u1), .Uses_rs2_id(v.u2), .halt_id(v.halt_id),
        .valid_ex(v.valid_ex), .Rsrc1_ex(v.rs1_ex), .Rsrc2_ex(v.rs2_ex),
        .RegDst_ex(v.rd_ex), .RWrEn_ex(v.rwen_ex), .WBSel_ex(v.wbsel_ex),
        .BrTaken_ex(v.br), .valid_mem(v.valid_mem), .Rdst_mem(v.rd_mem),
        .RWrEn_mem(v.rwen_mem), .mem_busy(v.busy), .valid_wb(v.valid_wb),
        .Rdst_wb(v.rd_wb), .RWrEn_wb(v.rwen_wb), .halt_wb(v.halt_wb),
        .pc_hold(b_ph), .stall_if_id(b_sif), .stall_id_ex(b_sid),
        .squash_if_id(b_qif), .squash_id_ex(b_qid), .WEN_back(b_wen),
        .FwdA_ex(b_fa), .FwdB_ex(b_fb), .halt_out(b_ho),
        .stall_cnt(b_sc), .squash_cnt(b_qc)
    );

    exp_t ga, gb;
    assign ga = '{a_ph, a_sif, a_sid, a_qif, a_qid, a_wen, a_fa, a_fb, a_ho, 32'(a_sc), 32'(a_qc)};
    assign gb = '{b_ph, b_sif, b_sid, b_qif, b_qid, b_wen, b_fa, b_fb, b_ho, b_sc, b_qc};

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;
    mst_t ma, mb;

    function automatic logic [1:0] fwd(input in_t x, input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (x.valid_mem && !x.rwen_mem && x.rd_mem == rs) return 2'b01;
        if (x.valid_wb && !x.rwen_wb && x.rd_wb == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic longint sat_inc(input longint c, input longint maxc);
        return (c >= maxc) ? maxc : c + 1;
    endfunction

    // Reference: outputs for this cycle from the current mode, then advance the mode.
    task automatic model(inout mst_t m, input in_t x, input int bubbles,
                         input longint maxc, output exp_t e);
        bit lu;
        e    = '0;
        e.ho = m.halted;
        e.sc = 32'(m.scnt);
        e.qc = 32'(m.qcnt);
        e.fa = fwd(x, x.rs1_ex);
        e.fb = fwd(x, x.rs2_ex);
        lu = x.valid_ex && x.wbsel_ex == 2'b10 && !x.rwen_ex && x.rd_ex != 0 && x.valid_id &&
             ((x.u1 && x.rs1_id == x.rd_ex) || (x.u2 && x.rs2_id == x.rd_ex));
        if (m.halted) begin
            {e.ph, e.sif, e.sid, e.wen} = 4'hF;
        end else if (x.busy) begin
            {e.ph, e.sif, e.sid, e.wen} = 4'hF;
            m.scnt = sat_inc(m.scnt, maxc);
        end else if (x.br) begin
            e.qif = 1; e.qid = 1;
            m.qcnt     = sat_inc(m.qcnt, maxc);
            m.draining = 0;
            m.lu_left  = 0;
        end else if (m.lu_left > 0) begin
            e.ph = 1; e.sif = 1; e.qid = 1;
            m.scnt    = sat_inc(m.scnt, maxc);
            m.lu_left = m.lu_left - 1;
        end else if (m.draining) begin
            e.ph = 1; e.qif = 1;
            if (x.halt_wb) begin m.halted = 1; m.draining = 0; end
        end else if (lu) begin
            e.ph = 1; e.sif = 1; e.qid = 1;
            m.scnt    = sat_inc(m.scnt, maxc);
            m.lu_left = bubbles - 1;
        end else if (x.halt_id && x.valid_id) begin
            m.draining = 1;
        end
    endtask

    task automatic cyc(input in_t x, input bit r);
        exp_t ea, eb;
        @(posedge CLK);
        #1;
        RST = r;
        v   = x;
        if (r) begin ma = '{0, 0, 0, 0, 0}; mb = '{0, 0, 0, 0, 0}; end
        model(ma, x, 1, 15, ea);
        model(mb, x, 3, 64'hFFFF_FFFF, eb);
        if (r) begin ma = '{0, 0, 0, 0, 0}; mb = '{0, 0, 0, 0, 0}; end
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    always @(negedge CLK) begin
        exp_t e;
        cyc_n++;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            total++;
            if (ga !== e) begin
                bad++;
                $display("FAIL dut_a cycle %0d: got %h expected %h", cyc_n, ga, e);
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            total++;
            if (gb !== e) begin
                bad++;
                $display("FAIL dut_b cycle %0d: got %h expected %h", cyc_n, gb, e);
            end
        end
    end

    function automatic in_t lw_use(input logic [4:0] rd);
        in_t x = '0;
        x.valid_ex = 1; x.wbsel_ex = 2'b10; x.rwen_ex = 0; x.rd_ex = rd;
        x.valid_id = 1; x.u1 = 1; x.rs1_id = rd;
        x.rwen_mem = 1; x.rwen_wb = 1;
        return x;
    endfunction

    function automatic in_t rnd();
        in_t x;
        x.valid_id  = ($urandom_range(0, 99) < 80);
        x.rs1_id    = 5'($urandom_range(0, 3));
        x.rs2_id    = 5'($urandom_range(0, 3));
        x.u1        = 1'($urandom);
        x.u2        = 1'($urandom);
        x.halt_id   = ($urandom_range(0, 99) < 4);
        x.valid_ex  = ($urandom_range(0, 99) < 80);
        x.rs1_ex    = 5'($urandom_range(0, 3));
        x.rs2_ex    = 5'($urandom_range(0, 3));
        x.rd_ex     = 5'($urandom_range(0, 3));
        x.rwen_ex   = 1'($urandom);
        x.wbsel_ex  = 2'($urandom);
        x.br        = ($urandom_range(0, 99) < 10);
        x.valid_mem = 1'($urandom);
        x.rd_mem    = 5'($urandom_range(0, 3));
        x.rwen_mem  = 1'($urandom);
        x.busy      = ($urandom_range(0, 99) < 15);
        x.valid_wb  = 1'($urandom);
        x.rd_wb     = 5'($urandom_range(0, 3));
        x.rwen_wb   = 1'($urandom);
        x.halt_wb   = ($urandom_range(0, 99) < 20);
        return x;
    endfunction

    initial begin
        in_t x;
        in_t idle;
        idle = '0;
        idle.rwen_ex = 1; idle.rwen_mem = 1; idle.rwen_wb = 1;

        // reset state
        cyc(idle, 1);
        cyc(idle, 0);

        // forwarding: MEM and WB both write x5 -> MEM; x0 never forwarded
        x = idle;
        x.valid_mem = 1; x.rd_mem = 5; x.rwen_mem = 0;
        x.valid_wb  = 1; x.rd_wb  = 5; x.rwen_wb  = 0;
        x.rs1_ex = 5; x.rs2_ex = 5;
        cyc(x, 0);
        x.rd_mem = 0;
        cyc(x, 0);
        x.rd_wb = 0; x.rs1_ex = 0; x.rs2_ex = 0;
        cyc(x, 0);

        // load-use (A: 1 bubble, B: 3 bubbles), held hazard then idle
        cyc(lw_use(3), 0);
        repeat (4) cyc(idle, 0);

        // branch overrides load-use
        x = lw_use(3); x.br = 1;
        cyc(x, 0);
        cyc(idle, 0);

        // mem_busy for 4 cycles during a taken branch, branch resolves on cycle 5
        x = idle; x.br = 1; x.busy = 1;
        repeat (4) cyc(x, 0);
        x.busy = 0;
        cyc(x, 0);
        cyc(idle, 0);

        // halt drain, halt reaches WB 3 cycles later, halted state held
        x = idle; x.valid_id = 1; x.halt_id = 1;
        cyc(x, 0);
        repeat (2) cyc(idle, 0);
        x = idle; x.halt_wb = 1;
        cyc(x, 0);
        x = idle; x.busy = 1; x.br = 1;
        repeat (3) cyc(x, 0);

        // reset pulse mid-drain
        cyc(idle, 1);
        x = idle; x.valid_id = 1; x.halt_id = 1;
        cyc(x, 0);
        cyc(lw_use(2), 0);
        cyc(idle, 1);
        cyc(lw_use(2), 0);
        repeat (3) cyc(idle, 0);

        // randomized traffic with occasional resets to leave HALTED
        for (int i = 0; i < 3000; i++)
            cyc(rnd(), ($urandom_range(0, 99) == 0));

        for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++)
            @(negedge CLK);
        if (qa.size() > 0 || qb.size() > 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected 0", qa.size() + qb.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
